// File: rtl/decode_control_pkg.sv
// Shared constants for the ID-stage control decoder: RV32 opcodes, ALU operation
// and operand-source codes, the ID/EX control bundle type and its bubble value.
package decode_control_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALU_OP_LOAD_STORE = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH     = 2'b01;
    localparam logic [1:0] ALU_OP_REG        = 2'b10;
    localparam logic [1:0] ALU_OP_IMM        = 2'b11;

    localparam logic ALU_SRC_REG = 1'b0;
    localparam logic ALU_SRC_IMM = 1'b1;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       mul_div;
        logic       valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        alu_op:     ALU_OP_REG,
        alu_src:    1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        branch:     1'b0,
        jump:       1'b0,
        mul_div:    1'b0,
        valid:      1'b0
    };

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    function automatic logic load_use_hazard(
        input logic       valid,
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return valid && ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == rs1) || (ex_rd == rs2));
    endfunction

endpackage

// File: rtl/decode_control_ctrl_decode.sv
// Purely combinational opcode decoder producing the ID/EX control bundle
// for one instruction; flags opcodes it does not recognise.
module ctrl_decode
    import decode_control_pkg::*;
#(
    parameter int EN_M = 1
) (
    input  logic [6:0] i_opcode,
    input  logic [6:0] i_funct7,
    output ctrl_t      o_ctrl,
    output logic       o_illegal
);

    logic w_is_muldiv;

    assign w_is_muldiv = (EN_M != 0) && (i_funct7 == FUNCT7_MULDIV);

    always_comb begin
        o_ctrl    = CTRL_BUBBLE;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_OP: begin
                o_ctrl.alu_op    = ALU_OP_REG;
                o_ctrl.alu_src   = ALU_SRC_REG;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.mul_div   = w_is_muldiv;
                o_ctrl.valid     = 1'b1;
            end
            OPC_OP_IMM: begin
                o_ctrl.alu_op    = ALU_OP_IMM;
                o_ctrl.alu_src   = ALU_SRC_IMM;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.valid     = 1'b1;
            end
            OPC_LOAD: begin
                o_ctrl.alu_op     = ALU_OP_IMM;
                o_ctrl.alu_src    = ALU_SRC_IMM;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.valid      = 1'b1;
            end
            OPC_STORE: begin
                o_ctrl.alu_op    = ALU_OP_LOAD_STORE;
                o_ctrl.alu_src   = ALU_SRC_IMM;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.valid     = 1'b1;
            end
            OPC_BRANCH: begin
                o_ctrl.alu_op  = ALU_OP_BRANCH;
                o_ctrl.alu_src = ALU_SRC_REG;
                o_ctrl.branch  = 1'b1;
                o_ctrl.valid   = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // The ALU computes the link/target address as an add
                o_ctrl.alu_op    = ALU_OP_LOAD_STORE;
                o_ctrl.alu_src   = ALU_SRC_IMM;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.jump      = 1'b1;
                o_ctrl.valid     = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_control.sv
// ID-stage control: decodes the instruction, detects load-use hazards, holds ID
// for multi-cycle mul/div ops and registers the ID/EX control bundle.
module decode_control
    import decode_control_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int EN_M       = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       Valid_i,
    input  logic [6:0] Opcode_i,
    input  logic [6:0] Funct7_i,
    input  logic [4:0] Rs1_i,
    input  logic [4:0] Rs2_i,
    input  logic       ExMemRead_i,
    input  logic [4:0] ExRd_i,
    input  logic       NoOp_i,
    output logic [1:0] ALUOp_o,
    output logic       ALUSrc_o,
    output logic       RegWrite_o,
    output logic       MemToReg_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       Branch_o,
    output logic       Jump_o,
    output logic       MulDiv_o,
    output logic       Valid_o,
    output logic       Stall_o,
    output logic       Illegal_o
);

    localparam logic       MD_STALLS = (MULDIV_LAT > 1);
    localparam logic [3:0] MD_LOAD   = 4'(MULDIV_LAT - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    ctrl_t      r_bundle;
    ctrl_t      w_bundle_next;
    logic       r_illegal;
    logic       w_illegal_next;

    ctrl_t      w_dec;
    logic       w_dec_illegal;
    logic       w_hazard;
    logic       w_busy;
    logic       w_issue;

    ctrl_decode #(
        .EN_M (EN_M)
    ) u_ctrl_decode (
        .i_opcode  (Opcode_i),
        .i_funct7  (Funct7_i),
        .o_ctrl    (w_dec),
        .o_illegal (w_dec_illegal)
    );

    assign w_hazard = load_use_hazard(Valid_i, ExMemRead_i, ExRd_i, Rs1_i, Rs2_i);
    assign w_busy   = (r_state == ST_MD_BUSY);
    assign w_issue  = Valid_i && !w_dec_illegal && !w_hazard && !NoOp_i && !w_busy;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; a flush always wins and aborts any mul/div hold
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (NoOp_i) begin
            w_state_next = ST_RUN;
            w_cnt_next   = 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_issue && w_dec.mul_div && MD_STALLS) begin
                        w_state_next = ST_MD_BUSY;
                        w_cnt_next   = MD_LOAD;
                    end
                end
                ST_MD_BUSY: begin
                    if (r_cnt <= 4'd1) begin
                        w_state_next = ST_RUN;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = 4'd0;
                end
            endcase
        end
    end

    // Output logic; an illegal op only reports once it would otherwise issue
    always_comb begin
        w_bundle_next  = w_issue ? w_dec : CTRL_BUBBLE;
        w_illegal_next = Valid_i && w_dec_illegal && !NoOp_i && !w_busy && !w_hazard;
        Stall_o        = rst_n_i && !NoOp_i && (w_hazard || w_busy);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bundle  <= CTRL_BUBBLE;
            r_illegal <= 1'b0;
        end else begin
            r_bundle  <= w_bundle_next;
            r_illegal <= w_illegal_next;
        end
    end

    assign ALUOp_o    = r_bundle.alu_op;
    assign ALUSrc_o   = r_bundle.alu_src;
    assign RegWrite_o = r_bundle.reg_write;
    assign MemToReg_o = r_bundle.mem_to_reg;
    assign MemRead_o  = r_bundle.mem_read;
    assign MemWrite_o = r_bundle.mem_write;
    assign Branch_o   = r_bundle.branch;
    assign Jump_o     = r_bundle.jump;
    assign MulDiv_o   = r_bundle.mul_div;
    assign Valid_o    = r_bundle.valid;
    assign Illegal_o  = r_illegal;

endmodule

// File: tb/tb_decode_control.sv
// Directed bench for decode_control: decode table, load-use stall, mul/div hold,
// flush, illegal opcode and asynchronous reset, plus a MULDIV_LAT=1 instance.
module tb_decode_control;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] BAD    = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       exmr;
    logic [4:0] exrd;
    logic       noop;

    logic [1:0] alu_op;
    logic       alu_src, reg_wr, mem2reg, mem_rd, mem_wr, br, jmp, md, vld_o, stall, ill;
    logic [1:0] alu_op1;
    logic       alu_src1, reg_wr1, mem2reg1, mem_rd1, mem_wr1, br1, jmp1, md1, vld_o1, stall1, ill1;

    int n_cmp;
    int n_err;

    decode_control #(.MULDIV_LAT(4), .EN_M(1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .Valid_i(valid), .Opcode_i(opc), .Funct7_i(f7),
        .Rs1_i(rs1), .Rs2_i(rs2), .ExMemRead_i(exmr), .ExRd_i(exrd), .NoOp_i(noop),
        .ALUOp_o(alu_op), .ALUSrc_o(alu_src), .RegWrite_o(reg_wr), .MemToReg_o(mem2reg),
        .MemRead_o(mem_rd), .MemWrite_o(mem_wr), .Branch_o(br), .Jump_o(jmp),
        .MulDiv_o(md), .Valid_o(vld_o), .Stall_o(stall), .Illegal_o(ill)
    );

    decode_control #(.MULDIV_LAT(1), .EN_M(1)) u_dut_lat1 (
        .clk_i(clk), .rst_n_i(rst_n), .Valid_i(valid), .Opcode_i(opc), .Funct7_i(f7),
        .Rs1_i(rs1), .Rs2_i(rs2), .ExMemRead_i(exmr), .ExRd_i(exrd), .NoOp_i(noop),
        .ALUOp_o(alu_op1), .ALUSrc_o(alu_src1), .RegWrite_o(reg_wr1), .MemToReg_o(mem2reg1),
        .MemRead_o(mem_rd1), .MemWrite_o(mem_wr1), .Branch_o(br1), .Jump_o(jmp1),
        .MulDiv_o(md1), .Valid_o(vld_o1), .Stall_o(stall1), .Illegal_o(ill1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [6:0] o, input logic [6:0] f,
                          input logic [4:0] a, input logic [4:0] b,
                          input logic mr, input logic [4:0] rd, input logic n);
        valid = v; opc = o; f7 = f; rs1 = a; rs2 = b; exmr = mr; exrd = rd; noop = n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        // hazard-shaped inputs during reset must still leave Stall_o low
        set_in(1, OP, 7'd0, 5'd1, 5'd5, 1, 5'd5, 0);
        tick();
        chk("rst_valid", vld_o, 0);
        chk("rst_regwr", reg_wr, 0);
        chk("rst_aluop", alu_op, 2'b10);
        chk("rst_illegal", ill, 0);
        chk("rst_stall", stall, 0);
        rst_n = 1'b1;

        // ADD
        set_in(1, OP, 7'd0, 5'd1, 5'd2, 0, 5'd0, 0);
        #1 chk("add_stall", stall, 0);
        tick();
        chk("add_regwr", reg_wr, 1);
        chk("add_alusrc", alu_src, 0);
        chk("add_aluop", alu_op, 2'b10);
        chk("add_valid", vld_o, 1);
        chk("add_muldiv", md, 0);

        // Load-use on Rs2: one stall cycle, one bubble
        set_in(1, OP, 7'd0, 5'd1, 5'd5, 1, 5'd5, 0);
        #1 chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble_valid", vld_o, 0);
        chk("lu_bubble_regwr", reg_wr, 0);
        set_in(1, OP, 7'd0, 5'd1, 5'd5, 0, 5'd0, 0);
        #1 chk("lu_release", stall, 0);
        tick();
        chk("lu_issue_valid", vld_o, 1);
        // Same match but ExRd=x0: no stall; Rs1 match stalls
        set_in(1, OP, 7'd0, 5'd0, 5'd0, 1, 5'd0, 0);
        #1 chk("lu_x0_stall", stall, 0);
        set_in(1, OP, 7'd0, 5'd7, 5'd3, 1, 5'd7, 0);
        #1 chk("lu_rs1_stall", stall, 1);
        set_in(1, LOAD, 7'd0, 5'd1, 5'd2, 0, 5'd0, 0);
        tick();

        // LOAD / STORE / BRANCH / JAL / OP_IMM decode
        chk("ld_memrd", mem_rd, 1);
        chk("ld_mem2reg", mem2reg, 1);
        chk("ld_alusrc", alu_src, 1);
        chk("ld_aluop", alu_op, 2'b11);
        chk("ld_regwr", reg_wr, 1);
        set_in(1, STORE, 7'd0, 5'd1, 5'd2, 0, 5'd0, 0);
        tick();
        chk("st_memwr", mem_wr, 1);
        chk("st_aluop", alu_op, 2'b00);
        chk("st_regwr", reg_wr, 0);
        chk("st_alusrc", alu_src, 1);
        set_in(1, BRANCH, 7'd0, 5'd1, 5'd2, 0, 5'd0, 0);
        tick();
        chk("br_branch", br, 1);
        chk("br_regwr", reg_wr, 0);
        set_in(1, JAL, 7'd0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        chk("jal_jump", jmp, 1);
        chk("jal_regwr", reg_wr, 1);
        chk("jal_alusrc", alu_src, 1);
        set_in(1, OPIMM, 7'd0, 5'd1, 5'd0, 0, 5'd0, 0);
        tick();
        chk("imm_aluop", alu_op, 2'b11);
        chk("imm_alusrc", alu_src, 1);
        set_in(0, OP, 7'd0, 5'd1, 5'd2, 0, 5'd0, 0);
        tick();
        chk("novalid_bubble", vld_o, 0);

        // MUL, latency 4: issue, then three held cycles
        set_in(1, OP, 7'd1, 5'd1, 5'd2, 0, 5'd0, 0);
        #1 chk("mul_issue_stall", stall, 0);
        tick();
        chk("mul_muldiv", md, 1);
        chk("mul_valid", vld_o, 1);
        chk("lat1_muldiv", md1, 1);
        set_in(1, OP, 7'd0, 5'd3, 5'd4, 0, 5'd0, 0);
        #1 chk("md_busy1_stall", stall, 1);
        chk("lat1_nostall", stall1, 0);
        tick();
        chk("md_busy2_bubble", vld_o, 0);
        chk("md_busy2_muldiv", md, 0);
        set_in(1, OP, 7'd0, 5'd3, 5'd4, 1, 5'd4, 0);
        #1 chk("md_busy2_stall_lu", stall, 1);
        tick();
        set_in(1, OP, 7'd0, 5'd3, 5'd4, 0, 5'd0, 0);
        #1 chk("md_busy3_stall", stall, 1);
        chk("md_busy3_bubble", vld_o, 0);
        tick();
        chk("md_run_stall", stall, 0);
        chk("md_run_bubble", vld_o, 0);
        tick();
        chk("md_next_valid", vld_o, 1);
        chk("md_next_regwr", reg_wr, 1);

        // Flush in the second held cycle
        set_in(1, OP, 7'd1, 5'd1, 5'd2, 0, 5'd0, 0);
        tick();
        set_in(1, OP, 7'd0, 5'd3, 5'd4, 0, 5'd0, 0);
        tick();
        set_in(1, OP, 7'd0, 5'd3, 5'd4, 0, 5'd0, 1);
        #1 chk("flush_stall", stall, 0);
        tick();
        chk("flush_bubble", vld_o, 0);
        set_in(1, OP, 7'd0, 5'd3, 5'd4, 0, 5'd0, 0);
        #1 chk("flush_run_stall", stall, 0);
        tick();
        chk("flush_run_valid", vld_o, 1);

        // Illegal opcode, then illegal under flush
        set_in(1, BAD, 7'd0, 5'd1, 5'd2, 0, 5'd0, 0);
        tick();
        chk("ill_pulse", ill, 1);
        chk("ill_bubble", vld_o, 0);
        set_in(1, OP, 7'd0, 5'd1, 5'd2, 0, 5'd0, 0);
        tick();
        chk("ill_clear", ill, 0);
        set_in(1, BAD, 7'd0, 5'd1, 5'd2, 0, 5'd0, 1);
        tick();
        chk("ill_noop", ill, 0);
        chk("ill_noop_bubble", vld_o, 0);

        // Asynchronous reset while holding for a MUL
        set_in(1, OP, 7'd1, 5'd1, 5'd2, 0, 5'd0, 0);
        tick();
        set_in(1, OP, 7'd0, 5'd3, 5'd4, 0, 5'd0, 0);
        #1 chk("rst_md_pre_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_md_muldiv", md, 0);
        chk("rst_md_valid", vld_o, 0);
        chk("rst_md_stall", stall, 0);
        tick();
        rst_n = 1'b1;
        #1 chk("rst_md_after_stall", stall, 0);
        tick();
        chk("rst_md_after_valid", vld_o, 1);
        chk("rst_md_after_regwr", reg_wr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
